serializer_sequencer: RTL and testbench

//  Sequences one Serializer instance: accepts Q-vectors from upstream and drives serializer_update/_shift.

---
 rtl/nn_ctrl_pkg.sv | 14 +
 rtl/serializer_sequencer.sv | 127 ++++++++++++
 tb/tb_serializer_sequencer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/nn_ctrl_pkg.sv
// Shared control definitions for the NN datapath sequencers and the Serializer.
package nn_ctrl_pkg;

   localparam int unsigned DEFAULT_INPUT_SIZE = 16;
   localparam int unsigned DEFAULT_Q_SIZE     = 8;

   typedef enum logic [1:0] {
      SEQ_IDLE,
      SEQ_LOAD,
      SEQ_STREAM,
      SEQ_DONE
   } seq_state_t;

endpackage

// File: rtl/serializer_sequencer.sv
// Sequences one Serializer: loads a vector on the LOAD handshake, then shifts out the
// remaining INPUT_SIZE-1 elements back to back, tagging each with index and first/last flags.
module serializer_sequencer
   import nn_ctrl_pkg::*;
#(
   parameter  int unsigned INPUT_SIZE  = DEFAULT_INPUT_SIZE,
   parameter  int unsigned MAX_VECTORS = 1024,
   localparam int unsigned IDX_W       = $clog2(INPUT_SIZE),
   localparam int unsigned VEC_W       = $clog2(MAX_VECTORS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [VEC_W-1:0] num_vectors,
   input  logic             vec_valid,
   output logic             vec_ready,
   output logic             serializer_update,
   output logic             serializer_shift,
   output logic             elem_valid,
   output logic [IDX_W-1:0] elem_idx,
   output logic             first_elem,
   output logic             last_elem,
   output logic [VEC_W-1:0] vec_idx,
   output logic             last_vec,
   output logic             busy,
   output logic             done
);

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(INPUT_SIZE - 1);

   seq_state_t       state_q, state_d;
   logic [IDX_W-1:0] elem_idx_q, elem_idx_d;
   logic [VEC_W-1:0] vec_idx_q, vec_idx_d;
   logic [VEC_W-1:0] num_vectors_q, num_vectors_d;
   logic             on_last_vec;

   // State and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= SEQ_IDLE;
         elem_idx_q    <= '0;
         vec_idx_q     <= '0;
         num_vectors_q <= '0;
      end else begin
         state_q       <= state_d;
         elem_idx_q    <= elem_idx_d;
         vec_idx_q     <= vec_idx_d;
         num_vectors_q <= num_vectors_d;
      end
   end

   assign on_last_vec = (vec_idx_q == VEC_W'(num_vectors_q - VEC_W'(1)));

   // Next-state and strobe decode
   always_comb begin
      state_d          = state_q;
      elem_idx_d       = elem_idx_q;
      vec_idx_d        = vec_idx_q;
      num_vectors_d    = num_vectors_q;
      vec_ready        = 1'b0;
      serializer_shift = 1'b0;
      elem_valid       = 1'b0;
      done             = 1'b0;

      case (state_q)
         SEQ_IDLE: begin
            if (start) begin
               num_vectors_d = num_vectors;
               vec_idx_d     = '0;
               elem_idx_d    = '0;
               state_d       = (num_vectors == '0) ? SEQ_DONE : SEQ_LOAD;
            end
         end
         SEQ_LOAD: begin
            vec_ready = 1'b1;
            if (vec_valid) begin
               elem_valid = 1'b1;
               elem_idx_d = IDX_W'(1);
               state_d    = SEQ_STREAM;
            end
         end
         SEQ_STREAM: begin
            // Serializer cannot hold, so streaming never stalls
            serializer_shift = 1'b1;
            elem_valid       = 1'b1;
            if (elem_idx_q == IDX_LAST) begin
               elem_idx_d = '0;
               if (on_last_vec) begin
                  state_d = SEQ_DONE;
               end else begin
                  vec_idx_d = vec_idx_q + VEC_W'(1);
                  state_d   = SEQ_LOAD;
               end
            end else begin
               elem_idx_d = elem_idx_q + IDX_W'(1);
            end
         end
         SEQ_DONE: begin
            done    = 1'b1;
            state_d = SEQ_IDLE;
         end
         default: state_d = SEQ_IDLE;
      endcase

      // Abort overrides everything; vec_ready drops too so no handshake can complete
      if (abort && (state_q != SEQ_IDLE)) begin
         state_d          = SEQ_IDLE;
         elem_idx_d       = '0;
         vec_idx_d        = vec_idx_q;
         num_vectors_d    = num_vectors_q;
         vec_ready        = 1'b0;
         serializer_shift = 1'b0;
         elem_valid       = 1'b0;
         done             = 1'b0;
      end
   end

   assign serializer_update = vec_valid & vec_ready;
   assign elem_idx          = elem_idx_q;
   assign vec_idx           = vec_idx_q;
   assign first_elem        = elem_valid & (elem_idx_q == '0);
   assign last_elem         = elem_valid & (elem_idx_q == IDX_LAST);
   assign last_vec          = elem_valid & on_last_vec;
   assign busy              = (state_q != SEQ_IDLE);

endmodule

// File: tb/tb_serializer_sequencer.sv
// Directed bench for serializer_sequencer: per-cycle vector table plus hand sequences
// for start re-assertion, asynchronous reset and a Serializer-model scoreboard.
module tb_serializer_sequencer;
   import nn_ctrl_pkg::*;

   localparam int unsigned IS    = 4;
   localparam int unsigned MAXV  = 1024;
   localparam int unsigned IDX_W = $clog2(IS);
   localparam int unsigned VEC_W = $clog2(MAXV + 1);
   localparam int unsigned EXP_W = 4 + IDX_W + 2 + VEC_W + 3;
   localparam int unsigned Q     = DEFAULT_Q_SIZE;
   localparam int unsigned NV6   = 5;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic [VEC_W-1:0] num_vectors = '0;
   logic             vec_valid = 1'b0;
   logic             vec_ready, serializer_update, serializer_shift, elem_valid;
   logic [IDX_W-1:0] elem_idx;
   logic             first_elem, last_elem, last_vec, busy, done;
   logic [VEC_W-1:0] vec_idx;

   serializer_sequencer #(.INPUT_SIZE(IS), .MAX_VECTORS(MAXV)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .num_vectors(num_vectors), .vec_valid(vec_valid), .vec_ready(vec_ready),
      .serializer_update(serializer_update), .serializer_shift(serializer_shift),
      .elem_valid(elem_valid), .elem_idx(elem_idx), .first_elem(first_elem),
      .last_elem(last_elem), .vec_idx(vec_idx), .last_vec(last_vec),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit               rst;
      bit               st;
      bit               vv;
      bit               ab;
      logic [VEC_W-1:0] nv;
      logic [EXP_W-1:0] exp;
   } row_t;

   row_t rows[$];
   int   n_cmp = 0;
   int   n_fail = 0;

   // exp fields: ready upd shift ev idx first last vidx lastvec busy done
   function automatic void add_row(input bit rst, input bit st, input bit vv, input bit ab, input int nv,
                                   input bit rdy, input bit upd, input bit sh, input bit ev, input int idx,
                                   input bit fe, input bit le, input int vi, input bit lv, input bit bs,
                                   input bit dn);
      row_t r;
      r.rst = rst; r.st = st; r.vv = vv; r.ab = ab; r.nv = VEC_W'(nv);
      r.exp = {rdy, upd, sh, ev, IDX_W'(idx), fe, le, VEC_W'(vi), lv, bs, dn};
      rows.push_back(r);
   endfunction

   function automatic logic [EXP_W-1:0] act_bits();
      return {vec_ready, serializer_update, serializer_shift, elem_valid, elem_idx,
              first_elem, last_elem, vec_idx, last_vec, busy, done};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; vec_valid = 1'b0; num_vectors = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic drive(input bit st, input bit vv, input bit ab, input int nv);
      @(negedge clk);
      start = st; vec_valid = vv; abort = ab; num_vectors = VEC_W'(nv);
      #1;
   endtask

   logic [Q-1:0] vecs [NV6][IS];
   logic [Q-1:0] sreg [IS-1];
   logic [Q-1:0] got, expv;

   initial begin
      // 1: three vectors, vec_valid held high
      add_row(1,1,1,0,3, 0,0,0,0,0,0,0,0,0,0,0);
      add_row(0,0,1,0,3, 1,1,0,1,0,1,0,0,0,1,0);
      add_row(0,0,1,0,3, 0,0,1,1,1,0,0,0,0,1,0);
      add_row(0,0,1,0,3, 0,0,1,1,2,0,0,0,0,1,0);
      add_row(0,0,1,0,3, 0,0,1,1,3,0,1,0,0,1,0);
      add_row(0,0,1,0,3, 1,1,0,1,0,1,0,1,0,1,0);
      add_row(0,0,1,0,3, 0,0,1,1,1,0,0,1,0,1,0);
      add_row(0,0,1,0,3, 0,0,1,1,2,0,0,1,0,1,0);
      add_row(0,0,1,0,3, 0,0,1,1,3,0,1,1,0,1,0);
      add_row(0,0,1,0,3, 1,1,0,1,0,1,0,2,1,1,0);
      add_row(0,0,1,0,3, 0,0,1,1,1,0,0,2,1,1,0);
      add_row(0,0,1,0,3, 0,0,1,1,2,0,0,2,1,1,0);
      add_row(0,0,1,0,3, 0,0,1,1,3,0,1,2,1,1,0);
      add_row(0,0,1,0,3, 0,0,0,0,0,0,0,2,0,1,1);
      add_row(0,0,1,0,3, 0,0,0,0,0,0,0,2,0,0,0);
      // 2: two vectors, vec_valid low for cycles 1-3
      add_row(1,1,0,0,2, 0,0,0,0,0,0,0,0,0,0,0);
      add_row(0,0,0,0,2, 1,0,0,0,0,0,0,0,0,1,0);
      add_row(0,0,0,0,2, 1,0,0,0,0,0,0,0,0,1,0);
      add_row(0,0,0,0,2, 1,0,0,0,0,0,0,0,0,1,0);
      add_row(0,0,1,0,2, 1,1,0,1,0,1,0,0,0,1,0);
      add_row(0,0,1,0,2, 0,0,1,1,1,0,0,0,0,1,0);
      add_row(0,0,1,0,2, 0,0,1,1,2,0,0,0,0,1,0);
      add_row(0,0,1,0,2, 0,0,1,1,3,0,1,0,0,1,0);
      add_row(0,0,1,0,2, 1,1,0,1,0,1,0,1,1,1,0);
      add_row(0,0,1,0,2, 0,0,1,1,1,0,0,1,1,1,0);
      add_row(0,0,1,0,2, 0,0,1,1,2,0,0,1,1,1,0);
      add_row(0,0,1,0,2, 0,0,1,1,3,0,1,1,1,1,0);
      add_row(0,0,1,0,2, 0,0,0,0,0,0,0,1,0,1,1);
      add_row(0,0,1,0,2, 0,0,0,0,0,0,0,1,0,0,0);
      // 3: zero vectors goes straight to DONE
      add_row(1,1,1,0,0, 0,0,0,0,0,0,0,0,0,0,0);
      add_row(0,0,1,0,0, 0,0,0,0,0,0,0,0,0,1,1);
      add_row(0,0,1,0,0, 0,0,0,0,0,0,0,0,0,0,0);
      // 4: abort in STREAM at elem_idx 2
      add_row(1,1,1,0,2, 0,0,0,0,0,0,0,0,0,0,0);
      add_row(0,0,1,0,2, 1,1,0,1,0,1,0,0,0,1,0);
      add_row(0,0,1,0,2, 0,0,1,1,1,0,0,0,0,1,0);
      add_row(0,0,1,1,2, 0,0,0,0,2,0,0,0,0,1,0);
      add_row(0,0,1,0,2, 0,0,0,0,0,0,0,0,0,0,0);
      add_row(0,0,1,0,2, 0,0,0,0,0,0,0,0,0,0,0);
      // abort during DONE suppresses the pulse; abort in LOAD blocks the handshake
      add_row(1,1,1,0,0, 0,0,0,0,0,0,0,0,0,0,0);
      add_row(0,0,1,1,0, 0,0,0,0,0,0,0,0,0,1,0);
      add_row(0,0,1,0,0, 0,0,0,0,0,0,0,0,0,0,0);
      add_row(0,1,1,0,1, 0,0,0,0,0,0,0,0,0,0,0);
      add_row(0,0,1,1,1, 0,0,0,0,0,0,0,0,0,1,0);
      add_row(0,0,1,0,1, 0,0,0,0,0,0,0,0,0,0,0);

      for (int i = 0; i < rows.size(); i++) begin
         if (rows[i].rst) do_reset();
         drive(rows[i].st, rows[i].vv, rows[i].ab, int'(rows[i].nv));
         check($sformatf("row%0d", i), 64'(act_bits()), 64'(rows[i].exp));
      end

      // 5: start re-asserted mid-run is ignored; asynchronous reset clears outputs
      do_reset();
      drive(1, 1, 0, 3);
      drive(0, 1, 0, 3);
      drive(0, 1, 0, 3);
      drive(1, 1, 0, 1);
      check("restart_c3", 64'(act_bits()), 64'({4'b0011, IDX_W'(2), 2'b00, VEC_W'(0), 3'b010}));
      drive(0, 1, 0, 1);
      check("restart_c4", 64'(act_bits()), 64'({4'b0011, IDX_W'(3), 2'b01, VEC_W'(0), 3'b010}));
      drive(0, 1, 0, 1);
      check("restart_c5", 64'(act_bits()), 64'({4'b1101, IDX_W'(0), 2'b10, VEC_W'(1), 3'b010}));
      drive(0, 1, 0, 1);
      check("restart_c6", 64'(act_bits()), 64'({4'b0011, IDX_W'(1), 2'b00, VEC_W'(1), 3'b010}));
      rst_n = 1'b0;
      #1;
      check("async_rst", 64'(act_bits()), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // 6: Serializer model scoreboard with random vec_valid gaps
      begin
         int lptr = 0, consumed = 0, first_cnt = 0, last_cnt = 0, lv_cnt = 0, lvl_cnt = 0;
         int done_cnt = 0, excl_err = 0;
         bit finished = 1'b0;
         for (int v = 0; v < NV6; v++)
            for (int e = 0; e < IS; e++) vecs[v][e] = Q'($urandom);
         for (int k = 0; k < IS - 1; k++) sreg[k] = '0;
         do_reset();
         for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            drive(cyc == 0, $urandom_range(0, 9) < 6, 0, NV6);
            if (serializer_update && serializer_shift) excl_err++;
            if (elem_valid && consumed < NV6 * IS) begin
               got  = (serializer_update && lptr < NV6) ? vecs[lptr][0] : sreg[0];
               expv = vecs[consumed / IS][consumed % IS];
               check($sformatf("sb_elem%0d", consumed), 64'({got, elem_idx}),
                     64'({expv, IDX_W'(consumed % IS)}));
               consumed++;
            end else if (elem_valid) begin
               consumed++;
            end
            if (first_elem) first_cnt++;
            if (last_elem) last_cnt++;
            if (last_vec) lv_cnt++;
            if (last_vec && last_elem) lvl_cnt++;
            if (done) begin done_cnt++; finished = 1'b1; end
            if (serializer_update && lptr < NV6) begin
               for (int k = 1; k < IS; k++) sreg[k-1] = vecs[lptr][k];
               lptr++;
            end else if (serializer_shift) begin
               for (int k = 0; k < IS - 2; k++) sreg[k] = sreg[k+1];
            end
         end
         check("sb_finished", 64'(finished), 64'(1));
         check("sb_consumed", 64'(consumed), 64'(NV6 * IS));
         check("sb_first_cnt", 64'(first_cnt), 64'(NV6));
         check("sb_last_cnt", 64'(last_cnt), 64'(NV6));
         check("sb_lastvec_cnt", 64'(lv_cnt), 64'(IS));
         check("sb_lastvec_last", 64'(lvl_cnt), 64'(1));
         check("sb_done_cnt", 64'(done_cnt), 64'(1));
         check("sb_upd_shift_excl", 64'(excl_err), 64'(0));
         drive(0, 0, 0, 0);
         check("sb_idle_after", 64'(busy), 64'(0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
